panda_data_bus_adapter: RTL and testbench

Sequential bridge between the single-cycle core's load/store unit and a request/grant/response (OBI-style) data bus. Takes the LSU's combinational word-aligned address, byte write-enables and write data, issues one bus transaction per memory instruction, and stalls the core until the response arrives. It then presents the registered load word back to the LSU for alignment and sign extension. A watchdog counter converts a missing response into an error.

---
 rtl/panda_pkg.sv | 20 ++
 rtl/panda_data_bus_adapter.sv | 132 +++++++++++++
 tb/tb_panda_data_bus_adapter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/panda_pkg.sv
// -----------------------------------------------------------------------------
// panda_pkg
// Shared types and constants for the panda single-cycle core.
//   bus_state_e     : states of the data-bus adapter transaction FSM
//   BUS_BE_WORD     : byte-enable pattern used for full-word loads
//   BUS_TIMEOUT_W   : width of the data-bus response watchdog counter
// -----------------------------------------------------------------------------
package panda_pkg;

  typedef enum logic [1:0] {
    BUS_IDLE = 2'd0,  // no transaction; a memory instruction issues from here
    BUS_REQ  = 2'd1,  // request raised, waiting for grant
    BUS_WAIT = 2'd2,  // granted, waiting for the response
    BUS_DONE = 2'd3   // response captured; the instruction retires this cycle
  } bus_state_e;

  localparam logic [3:0] BUS_BE_WORD   = 4'b1111;
  localparam int unsigned BUS_TIMEOUT_W = 16;

endpackage : panda_pkg

// File: rtl/panda_data_bus_adapter.sv
// -----------------------------------------------------------------------------
// panda_data_bus_adapter
// Bridges the single-cycle core's load/store unit to a request/grant/response
// data bus. One bus transaction is issued per memory instruction; the core is
// stalled until the response (or a watchdog timeout) arrives, then retires in
// a single non-stalled cycle using the registered response word.
//
// Parameters
//   TimeoutCycles : BUS_WAIT cycles tolerated before forcing an error (1..65535)
//
// Ports
//   clk_i, rst_i       : clock (rising edge), asynchronous active-high reset
//   data_req_i         : current instruction is a load or store
//   data_addr_i        : LSU address (bits [1:0] ignored)
//   data_we_i          : LSU byte write-enables, 4'b0000 means load
//   data_wdata_i       : LSU lane-aligned store data
//   data_rdata_o       : registered response word back to the LSU
//   data_err_o         : access faulted (bus error or timeout), valid in DONE
//   stall_o            : hold PC and register-file write this cycle
//   bus_req_o/gnt_i    : request / grant handshake
//   bus_addr_o, bus_we_o, bus_be_o, bus_wdata_o : transaction attributes
//   bus_rvalid_i, bus_rdata_i, bus_err_i        : response channel
// -----------------------------------------------------------------------------
module panda_data_bus_adapter
  import panda_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic [3:0]  data_we_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        stall_o,

  output logic        bus_req_o,
  input  logic        bus_gnt_i,
  output logic [31:0] bus_addr_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_err_i
);

  // Counter value seen in the last permitted BUS_WAIT cycle: the counter is
  // cleared on entry, so the TimeoutCycles-th wait cycle observes N-1.
  localparam logic [BUS_TIMEOUT_W-1:0] TimeoutLast =
    BUS_TIMEOUT_W'(TimeoutCycles - 1);

  bus_state_e               state_q;
  logic [31:0]              rdata_q;
  logic                     err_q;
  logic [BUS_TIMEOUT_W-1:0] timeout_cnt_q;

  // The bus is word-addressed; the LSU handles sub-word lane selection.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^data_addr_i[1:0];

  // ---------------------------------------------------------------------------
  // Transaction FSM, response capture and watchdog
  // ---------------------------------------------------------------------------
  // NOTE: state lives in always_ff with non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= BUS_IDLE;
      rdata_q       <= '0;
      err_q         <= 1'b0;
      timeout_cnt_q <= '0;
    end else begin
      unique case (state_q)
        BUS_IDLE: begin
          if (data_req_i) begin
            timeout_cnt_q <= '0;
            state_q       <= bus_gnt_i ? BUS_WAIT : BUS_REQ;
          end
        end

        // Core is stalled here, so address/enables/data stay stable.
        BUS_REQ: begin
          if (bus_gnt_i) begin
            timeout_cnt_q <= '0;
            state_q       <= BUS_WAIT;
          end
        end

        // A response on the final permitted cycle wins over the timeout.
        BUS_WAIT: begin
          if (bus_rvalid_i) begin
            rdata_q <= bus_rdata_i;
            err_q   <= bus_err_i;
            state_q <= BUS_DONE;
          end else if (timeout_cnt_q == TimeoutLast) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            state_q <= BUS_DONE;
          end else begin
            timeout_cnt_q <= timeout_cnt_q + 1'b1;
          end
        end

        // Retire cycle: the still-high data_req_i belongs to the instruction
        // that just completed, so it must not be re-issued.
        BUS_DONE: state_q <= BUS_IDLE;

        default:  state_q <= BUS_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Issue is combinational from IDLE so a granted request costs no extra cycle.
  assign bus_req_o    = ((state_q == BUS_IDLE) && data_req_i) || (state_q == BUS_REQ);
  assign stall_o      = data_req_i && (state_q != BUS_DONE);

  assign bus_addr_o   = {data_addr_i[31:2], 2'b00};
  assign bus_we_o     = |data_we_i;
  assign bus_be_o     = bus_we_o ? data_we_i : BUS_BE_WORD;
  assign bus_wdata_o  = data_wdata_i;

  assign data_rdata_o = rdata_q;
  assign data_err_o   = err_q;

endmodule : panda_data_bus_adapter

// File: tb/tb_panda_data_bus_adapter.sv
// -----------------------------------------------------------------------------
// tb_panda_data_bus_adapter
// Directed bench for panda_data_bus_adapter (TimeoutCycles = 4). Inputs are
// driven 1 time unit after the rising edge and outputs sampled 1 unit later.
// -----------------------------------------------------------------------------
module tb_panda_data_bus_adapter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        data_req_i;
  logic [31:0] data_addr_i;
  logic [3:0]  data_we_i;
  logic [31:0] data_wdata_i;
  logic [31:0] data_rdata_o;
  logic        data_err_o;
  logic        stall_o;
  logic        bus_req_o;
  logic        bus_gnt_i;
  logic [31:0] bus_addr_o;
  logic        bus_we_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_rvalid_i;
  logic [31:0] bus_rdata_i;
  logic        bus_err_i;

  int tests_run    = 0;
  int tests_failed = 0;

  panda_data_bus_adapter #(.TimeoutCycles(4)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .data_req_i   (data_req_i),
    .data_addr_i  (data_addr_i),
    .data_we_i    (data_we_i),
    .data_wdata_i (data_wdata_i),
    .data_rdata_o (data_rdata_o),
    .data_err_o   (data_err_o),
    .stall_o      (stall_o),
    .bus_req_o    (bus_req_o),
    .bus_gnt_i    (bus_gnt_i),
    .bus_addr_o   (bus_addr_o),
    .bus_we_o     (bus_we_o),
    .bus_be_o     (bus_be_o),
    .bus_wdata_o  (bus_wdata_o),
    .bus_rvalid_i (bus_rvalid_i),
    .bus_rdata_i  (bus_rdata_i),
    .bus_err_i    (bus_err_i)
  );

  always #5 clk_i = ~clk_i;

  // Advance to 1 unit after the next rising edge (drive point).
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; data_req_i = 1'b0; data_addr_i = '0; data_we_i = '0;
    data_wdata_i = '0; bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
    bus_rdata_i = '0; bus_err_i = 1'b0;
    #2;
    tests_run++; if (bus_req_o !== 1'b0) begin tests_failed++; $display("FAIL reset_bus_req: got %b want 0", bus_req_o); end
    tests_run++; if (stall_o !== 1'b0) begin tests_failed++; $display("FAIL reset_stall: got %b want 0", stall_o); end
    tests_run++; if (data_rdata_o !== 32'h0) begin tests_failed++; $display("FAIL reset_rdata: got %h want 0", data_rdata_o); end
    tests_run++; if (data_err_o !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b want 0", data_err_o); end
    data_req_i = 1'b1;
    #1;
    tests_run++; if (bus_req_o !== 1'b1) begin tests_failed++; $display("FAIL reset_req_follow: got %b want 1", bus_req_o); end
    tests_run++; if (stall_o !== 1'b1) begin tests_failed++; $display("FAIL reset_stall_follow: got %b want 1", stall_o); end
    data_req_i = 1'b0;
    step();
    rst_i = 1'b0;
    step();
  endtask

  task automatic test_load();
    // C1 IDLE: issue with same-cycle grant
    data_req_i = 1'b1; data_addr_i = 32'h0000_1237; data_we_i = 4'b0000; bus_gnt_i = 1'b1;
    #1;
    tests_run++; if (bus_req_o !== 1'b1) begin tests_failed++; $display("FAIL load_req: got %b want 1", bus_req_o); end
    tests_run++; if (bus_addr_o !== 32'h0000_1234) begin tests_failed++; $display("FAIL load_addr: got %h want 00001234", bus_addr_o); end
    tests_run++; if (bus_be_o !== 4'b1111) begin tests_failed++; $display("FAIL load_be: got %b want 1111", bus_be_o); end
    tests_run++; if (bus_we_o !== 1'b0) begin tests_failed++; $display("FAIL load_we: got %b want 0", bus_we_o); end
    tests_run++; if (stall_o !== 1'b1) begin tests_failed++; $display("FAIL load_stall_c1: got %b want 1", stall_o); end
    step();
    // C2 WAIT: response
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h89AB_67EF;
    #1;
    tests_run++; if (bus_req_o !== 1'b0) begin tests_failed++; $display("FAIL load_req_wait: got %b want 0", bus_req_o); end
    tests_run++; if (stall_o !== 1'b1) begin tests_failed++; $display("FAIL load_stall_c2: got %b want 1", stall_o); end
    step();
    // C3 DONE
    bus_rvalid_i = 1'b0; bus_rdata_i = '0;
    #1;
    tests_run++; if (stall_o !== 1'b0) begin tests_failed++; $display("FAIL load_stall_done: got %b want 0", stall_o); end
    tests_run++; if (data_rdata_o !== 32'h89AB_67EF) begin tests_failed++; $display("FAIL load_rdata: got %h want 89ab67ef", data_rdata_o); end
    tests_run++; if (data_err_o !== 1'b0) begin tests_failed++; $display("FAIL load_err: got %b want 0", data_err_o); end
    tests_run++; if (bus_req_o !== 1'b0) begin tests_failed++; $display("FAIL load_req_done: got %b want 0", bus_req_o); end
    data_req_i = 1'b0;
    step();
  endtask

  task automatic test_store();
    data_req_i = 1'b1; data_addr_i = 32'h0000_0102; data_we_i = 4'b0100;
    data_wdata_i = 32'h0056_0000; bus_gnt_i = 1'b0;
    // Four request cycles: grant withheld for three, given on the fourth
    for (int c = 0; c < 4; c++) begin
      bus_gnt_i = (c == 3);
      #1;
      tests_run++; if (bus_req_o !== 1'b1) begin tests_failed++; $display("FAIL store_req_c%0d: got %b want 1", c, bus_req_o); end
      tests_run++; if (bus_addr_o !== 32'h0000_0100 || bus_be_o !== 4'b0100 || bus_we_o !== 1'b1 || bus_wdata_o !== 32'h0056_0000) begin
        tests_failed++; $display("FAIL store_attr_c%0d: got addr %h be %b we %b wdata %h want 00000100 0100 1 00560000", c, bus_addr_o, bus_be_o, bus_we_o, bus_wdata_o);
      end
      tests_run++; if (stall_o !== 1'b1) begin tests_failed++; $display("FAIL store_stall_c%0d: got %b want 1", c, stall_o); end
      step();
    end
    // WAIT cycle without response, grant ignored
    bus_gnt_i = 1'b1;
    #1;
    tests_run++; if (bus_req_o !== 1'b0 || stall_o !== 1'b1) begin tests_failed++; $display("FAIL store_wait1: got req %b stall %b want 0 1", bus_req_o, stall_o); end
    step();
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h1111_2222;
    #1;
    tests_run++; if (stall_o !== 1'b1) begin tests_failed++; $display("FAIL store_wait2_stall: got %b want 1", stall_o); end
    step();
    bus_rvalid_i = 1'b0;
    #1;
    tests_run++; if (stall_o !== 1'b0 || data_err_o !== 1'b0) begin tests_failed++; $display("FAIL store_done: got stall %b err %b want 0 0", stall_o, data_err_o); end
    data_req_i = 1'b0; data_we_i = 4'b0000;
    step();
  endtask

  task automatic test_bus_error();
    data_req_i = 1'b1; data_addr_i = 32'h0000_2000; bus_gnt_i = 1'b1;
    step();
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b1; bus_err_i = 1'b1; bus_rdata_i = 32'hDEAD_0000;
    step();
    bus_rvalid_i = 1'b0; bus_err_i = 1'b0;
    #1;
    tests_run++; if (data_err_o !== 1'b1) begin tests_failed++; $display("FAIL err_flag: got %b want 1", data_err_o); end
    tests_run++; if (stall_o !== 1'b0) begin tests_failed++; $display("FAIL err_stall_done: got %b want 0", stall_o); end
    tests_run++; if (data_rdata_o !== 32'hDEAD_0000) begin tests_failed++; $display("FAIL err_rdata: got %h want dead0000", data_rdata_o); end
    step();
    // Back in IDLE with the request still high: stalled again, so the
    // non-stalled window was exactly one cycle. Drop the request before issue.
    #1;
    tests_run++; if (stall_o !== 1'b1) begin tests_failed++; $display("FAIL err_stall_after: got %b want 1", stall_o); end
    data_req_i = 1'b0;
    #1;
    tests_run++; if (data_rdata_o !== 32'hDEAD_0000 || data_err_o !== 1'b1) begin tests_failed++; $display("FAIL err_hold: got %h %b want dead0000 1", data_rdata_o, data_err_o); end
    step();
  endtask

  task automatic test_timeout();
    data_req_i = 1'b1; data_addr_i = 32'h0000_3000; bus_gnt_i = 1'b1;
    step();
    bus_gnt_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      tests_run++; if (stall_o !== 1'b1) begin tests_failed++; $display("FAIL timeout_wait_c%0d: got stall %b want 1", c, stall_o); end
      step();
    end
    #1;
    tests_run++; if (stall_o !== 1'b0) begin tests_failed++; $display("FAIL timeout_stall_done: got %b want 0", stall_o); end
    tests_run++; if (data_rdata_o !== 32'h0 || data_err_o !== 1'b1) begin tests_failed++; $display("FAIL timeout_result: got %h %b want 0 1", data_rdata_o, data_err_o); end
    // Late response in DONE must be ignored
    data_req_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h0000_1234;
    step();
    bus_rvalid_i = 1'b0;
    step();
    tests_run++; if (data_rdata_o !== 32'h0 || data_err_o !== 1'b1) begin tests_failed++; $display("FAIL timeout_late_rvalid: got %h %b want 0 1", data_rdata_o, data_err_o); end
  endtask

  task automatic test_back_to_back();
    int hs = 0;
    logic [31:0] resp [2];
    resp[0] = 32'hCAFE_0001; resp[1] = 32'h0BAD_F00D;
    data_req_i = 1'b1; data_addr_i = 32'h0000_4000; bus_gnt_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      // Issue cycle
      #1;
      if (bus_req_o && bus_gnt_i) hs++;
      tests_run++; if (bus_req_o !== 1'b1) begin tests_failed++; $display("FAIL b2b_issue%0d: got req %b want 1", k, bus_req_o); end
      step();
      // WAIT: response, grant kept high
      bus_rvalid_i = 1'b1; bus_rdata_i = resp[k];
      #1;
      if (bus_req_o && bus_gnt_i) hs++;
      step();
      // DONE: grant still high, request still high
      bus_rvalid_i = 1'b0;
      #1;
      if (bus_req_o && bus_gnt_i) hs++;
      tests_run++; if (stall_o !== 1'b0 || data_rdata_o !== resp[k]) begin tests_failed++; $display("FAIL b2b_done%0d: got stall %b rdata %h want 0 %h", k, stall_o, data_rdata_o, resp[k]); end
      step();
    end
    data_req_i = 1'b0; bus_gnt_i = 1'b0;
    tests_run++; if (hs !== 2) begin tests_failed++; $display("FAIL b2b_handshakes: got %0d want 2", hs); end
    step();
  endtask

  task automatic test_reset_mid();
    data_req_i = 1'b1; data_addr_i = 32'h0000_5000; bus_gnt_i = 1'b1;
    step();
    bus_gnt_i = 1'b0;
    #1;
    tests_run++; if (bus_req_o !== 1'b0 || stall_o !== 1'b1) begin tests_failed++; $display("FAIL rstmid_wait: got req %b stall %b want 0 1", bus_req_o, stall_o); end
    rst_i = 1'b1;
    #1;
    // IDLE with the request still high: request reappears immediately
    tests_run++; if (bus_req_o !== 1'b1) begin tests_failed++; $display("FAIL rstmid_idle: got req %b want 1", bus_req_o); end
    tests_run++; if (data_rdata_o !== 32'h0 || data_err_o !== 1'b0) begin tests_failed++; $display("FAIL rstmid_clear: got %h %b want 0 0", data_rdata_o, data_err_o); end
    data_req_i = 1'b0;
    #1;
    tests_run++; if (bus_req_o !== 1'b0 || stall_o !== 1'b0) begin tests_failed++; $display("FAIL rstmid_drop: got req %b stall %b want 0 0", bus_req_o, stall_o); end
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'hFFFF_FFFF; bus_err_i = 1'b1;
    step();
    rst_i = 1'b0;
    step();
    step();
    bus_rvalid_i = 1'b0; bus_err_i = 1'b0;
    #1;
    tests_run++; if (data_rdata_o !== 32'h0 || data_err_o !== 1'b0 || stall_o !== 1'b0) begin tests_failed++; $display("FAIL rstmid_late_rvalid: got %h %b %b want 0 0 0", data_rdata_o, data_err_o, stall_o); end
    step();
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_bus_error();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_panda_data_bus_adapter
